imem_loader: RTL
================

Name: imem_loader

Overview:
- Writer side of the instruction-memory interface. The 16-bit processor core only reads instruction memory; this block is the party that fills it.
- Accepts a framed byte stream from a host over a valid/ready handshake and packs bytes into 16-bit instruction words.
- Writes each word through the instruction-memory write port and verifies a checksum at the end of the frame.
- Holds the processor stalled until a frame loads cleanly.

Parameters:
- ADDR_W, 4, instruction-memory address width.
- DEPTH, 16, number of instruction words (must be ≤ 2^ADDR_W).
- WORD_W, 16, instruction word width (fixed at 2 bytes).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to begin a load.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  loader can accept a byte.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  WORD_W  write data.
- cpu_hold  out  1  1 = processor stalled / PC held.
- busy  out  1  frame in progress.
- done  out  1  last frame loaded and checksum matched.
- error  out  1  last frame rejected.

Behaviour:
- Interface rule: one clock (clk); reset is synchronous and active-high (rst).
- Frame format, in order:
  - COUNT byte N, valid range 1..DEPTH.
  - 2N data bytes, high byte first per word.
  - One CHECK byte, equal to the XOR of all 2N data bytes. The COUNT byte is excluded from the XOR.
- Handshake: a byte transfers on a rising edge where in_valid && in_ready. in_data is ignored otherwise.
- in_ready is decoded combinationally from state: 1 in S_COUNT, S_HI, S_LO and S_CHECK; 0 elsewhere.
- States and transitions:
  - S_IDLE: start → S_COUNT.
  - S_COUNT: on accept, N==0 or N>DEPTH → S_ERR. Otherwise latch N, clear word index and XOR accumulator, → S_HI.
  - S_HI: on accept, latch high byte, XOR it in, → S_LO.
  - S_LO: on accept, XOR the byte in and schedule a write. If word index == N-1 → S_CHECK, else → S_HI.
  - S_CHECK: on accept, byte == accumulator → S_DONE, else → S_ERR.
  - S_DONE and S_ERR: start → S_COUNT, clearing done and error.
- Write timing:
  - imem_we is registered and high for exactly one cycle: the cycle after the S_LO accept.
  - In that cycle imem_addr = word index and imem_wdata = {hi, lo}.
  - The word index increments on the S_LO accept.
  - Back-to-back bytes are accepted with no bubble. A write may overlap acceptance of the next HI byte.
  - Writes go to addresses 0..N-1 only. The index never wraps past DEPTH-1 because N is range-checked.
- When imem_we is 0, imem_addr and imem_wdata hold their last values.
- Output behaviour:
  - cpu_hold = 1 in every state except S_DONE.
  - busy = 1 in S_COUNT, S_HI, S_LO and S_CHECK.
  - done = 1 only in S_DONE; error = 1 only in S_ERR.
  - On a checksum mismatch, the words already written stay in memory but cpu_hold remains 1.
- Reset values: in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_hold 1, busy 0, done 0, error 0. State S_IDLE, word index 0, accumulator 0.
- Boundary conditions:
  - start while busy is ignored and does not restart the frame.
  - start and a byte in the same cycle in S_IDLE: the byte is not accepted, because in_ready is 0 in S_IDLE.
  - rst mid-frame aborts on the next edge and returns all outputs to reset values. A pending imem_we is cancelled. Memory contents are not erased.
  - No timeout: the loader waits indefinitely for in_valid.

Test Plan:
- Nominal load, 3 words: after reset, send start, then bytes 03, 12,34, AB,CD, 00,01, then checksum 12^34^AB^CD^00^01 = 41.
  - Required: writes (0,1234), (1,ABCD), (2,0001), each a single-cycle imem_we.
  - Required: done=1 and cpu_hold=0 the cycle after the checksum byte is accepted.
- Checksum mismatch: same frame with checksum 40.
  - Required: 3 writes occur, then error=1, done=0, cpu_hold=1.
  - Follow with start plus a correct frame; required: done=1.
- Bad count: send N=00, then in a separate frame N=11 (17 > DEPTH).
  - Required: S_ERR with error=1 right after the count byte, and no imem_we pulse.
- Backpressure and gaps:
  - Drop in_valid randomly between bytes; required: identical writes to the nominal case.
  - Hold in_valid=1 continuously for a DEPTH=16 frame; required: 16 writes to addresses 0..15 with no missed bytes.
- Reset mid-frame: assert rst during the S_LO accept cycle of word 1.
  - Required: next cycle imem_we=0, cpu_hold=1, busy=0, in_ready=0.
  - Required: start followed by a full frame then loads normally.
- start ignored while busy: pulse start during S_HI.
  - Required: the frame continues unaffected and the write addresses do not reset.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus for imem_loader.
//   in_valid/in_data/in_ready : host byte stream, transfer when valid && ready
//   imem_we/imem_addr/imem_wdata : instruction-memory write port
// slave  : the loader's view (consumes bytes, drives the write port)
// master : the host/memory side of the same signals
interface imem_loader_if #(
  parameter int ADDR_W = 4,
  parameter int WORD_W = 16
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a framed byte stream
// (COUNT, 2*COUNT data bytes high-first, XOR CHECK byte), packs bytes into
// 16-bit words, writes them to instruction memory and keeps the CPU held
// until a frame has loaded with a matching checksum.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : one-cycle load request (ignored while busy)
//   bus       : imem_loader_if.slave (byte stream in, memory write port out)
//   cpu_hold  : 1 = processor stalled (every state except S_DONE)
//   busy      : frame in progress
//   done      : last frame loaded and checksum matched
//   error     : last frame rejected (bad count or checksum)
module imem_loader #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int WORD_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  imem_loader_if.slave   bus,
  output logic           cpu_hold,
  output logic           busy,
  output logic           done,
  output logic           error
);

  // Wide enough to hold the count value DEPTH itself.
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_HI, S_LO, S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [7:0]          hi_q, hi_d;
  logic [7:0]          acc_q, acc_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;

  logic                in_ready_s;
  logic                accept;
  logic                count_ok;
  logic                last_word;

  assign accept    = bus.in_valid && in_ready_s;
  assign count_ok  = (bus.in_data != 8'd0) && (int'(bus.in_data) <= DEPTH);
  assign last_word = (idx_q == count_q - CNT_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_COUNT;
      S_COUNT: if (accept) state_d = count_ok ? S_HI : S_ERR;
      S_HI:    if (accept) state_d = S_LO;
      S_LO:    if (accept) state_d = last_word ? S_CHECK : S_HI;
      S_CHECK: if (accept) state_d = (bus.in_data == acc_q) ? S_DONE : S_ERR;
      S_DONE:  if (start) state_d = S_COUNT;
      S_ERR:   if (start) state_d = S_COUNT;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready_s = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_hold   = 1'b1;
    case (state_q)
      S_COUNT, S_HI, S_LO, S_CHECK: begin
        in_ready_s = 1'b1;
        busy       = 1'b1;
      end
      S_DONE:  begin done = 1'b1; cpu_hold = 1'b0; end
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

  assign bus.in_ready = in_ready_s;

  // Datapath: count, word index, checksum and the registered write port
  always_comb begin
    count_d = count_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    acc_d   = acc_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      case (state_q)
        S_COUNT: if (count_ok) begin
          count_d = CNT_W'(bus.in_data);
          idx_d   = '0;
          acc_d   = '0;
        end
        S_HI: begin
          hi_d  = bus.in_data;
          acc_d = acc_q ^ bus.in_data;
        end
        S_LO: begin
          // The write lands the cycle after this accept, using the
          // pre-increment index; it may overlap the next HI accept.
          acc_d   = acc_q ^ bus.in_data;
          we_d    = 1'b1;
          addr_d  = ADDR_W'(idx_q);
          wdata_d = WORD_W'({hi_q, bus.in_data});
          idx_d   = idx_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      idx_q   <= '0;
      hi_q    <= '0;
      acc_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      count_q <= count_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      acc_q   <= acc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;

endmodule
